// File: rtl/sobel_frame_sched.sv
// ============================================================================
// Module   : sobel_frame_sched
// Brief    : Descriptor-queued frame controller with watchdog for a Sobel core
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_frame_sched #(
    parameter int DEPTH   = 4,
    parameter int BUF_W   = 2,
    parameter int TMO_W   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [BUF_W-1:0] req_src,
    input  logic [BUF_W-1:0] req_dst,
    input  logic [2:0]       req_key,
    input  logic [3:0]       req_tag,
    output logic             cmp_valid,
    input  logic             cmp_ready,
    output logic [3:0]       cmp_tag,
    output logic [1:0]       cmp_status,
    output logic             core_start,
    input  logic             core_done,
    input  logic             core_idle,
    output logic             core_rst,
    output logic [2:0]       core_key,
    output logic [BUF_W-1:0] core_src_sel,
    output logic [BUF_W-1:0] core_dst_sel,
    output logic             busy,
    output logic [15:0]      frames_done
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int DESC_W = 2 * BUF_W + 7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [DESC_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q;
    logic [2:0]        state_q, state_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              flush_q, flush_d;
    logic              status_q, status_d;
    logic [3:0]        tag_q;
    logic [2:0]        key_q;
    logic [BUF_W-1:0]  src_q, dst_q;
    logic              core_rst_q;
    logic              busy_q;
    logic [15:0]       frames_q;
    logic              push, pop;

    // Ready is registered from next occupancy so a full FIFO never accepts,
    // even when a pop happens in the same cycle.
    assign push    = req_valid & ready_q;
    assign pop     = (state_q == S_IDLE) && (count_q != '0) && core_idle;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge ap_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_src, req_dst, req_key, req_tag};
        end
    end

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        flush_d  = flush_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Done takes priority over a coincident watchdog expiry.
                if (core_done) begin
                    state_d  = S_REPORT;
                    status_d = 1'b0;
                end else if (wdog_q == C_TMO_LAST) begin
                    state_d = S_FLUSH;
                    flush_d = 1'b0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    state_d  = S_REPORT;
                    status_d = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_REPORT: begin
                if (cmp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            flush_q    <= 1'b0;
            status_q   <= 1'b0;
            tag_q      <= '0;
            key_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            frames_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {src_q, dst_q, key_q, tag_q} <= fifo_q[rd_ptr_q];
            end
            count_q    <= count_d;
            ready_q    <= (count_d != C_FULL);
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            flush_q    <= flush_d;
            status_q   <= status_d;
            core_rst_q <= (state_d == S_FLUSH);
            busy_q     <= (state_q != S_IDLE) || (count_q != '0);
            if ((state_q == S_REPORT) && cmp_ready && !status_q && (frames_q != 16'hFFFF)) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    assign req_ready    = ready_q;
    assign cmp_valid    = (state_q == S_REPORT);
    assign cmp_tag      = tag_q;
    assign cmp_status   = {1'b0, status_q};
    assign core_start   = (state_q == S_RUN);
    assign core_rst     = core_rst_q;
    assign core_key     = key_q;
    assign core_src_sel = src_q;
    assign core_dst_sel = dst_q;
    assign busy         = busy_q;
    assign frames_done  = frames_q;

endmodule

`default_nettype wire

// File: doc/sobel_frame_sched.md
# sobel_frame_sched

Frame-level controller for the `sobel_0_obf` edge-detection core. It queues frame descriptors from the host (source buffer, destination buffer, 3-bit working key, tag) in a small FIFO. It configures the core's key and buffer-select lines, drives the core's `ap_start`/`ap_done` handshake, and guards each frame with a watchdog. Each finished frame is reported on a completion channel. It sits between the host command interface and a single Sobel core instance, in the same clock domain.

## Interface
Parameters:
- DEPTH, 4, descriptor FIFO entries (power of two, ≥2)
- BUF_W, 2, frame-buffer bank select width
- TMO_W, 20, watchdog counter width
- TIMEOUT, 1000000, RUN-state cycles before a frame is aborted (must be < 2^TMO_W)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  descriptor offered
- req_ready  out  1  FIFO can accept (= not full)
- req_src  in  BUF_W  input frame bank
- req_dst  in  BUF_W  output frame bank
- req_key  in  3  working key for the core
- req_tag  in  4  host tag, returned on completion
- cmp_valid  out  1  completion record valid
- cmp_ready  in  1  host accepts completion
- cmp_tag  out  4  tag of finished frame
- cmp_status  out  2  00 = ok, 01 = timeout
- core_start  out  1  to core ap_start
- core_done  in  1  core ap_done
- core_idle  in  1  core ap_idle
- core_rst  out  1  active-high reset to core
- core_key  out  3  to core working_key
- core_src_sel  out  BUF_W  indata bank mux select
- core_dst_sel  out  BUF_W  outdata bank mux select
- busy  out  1  state ≠ IDLE or FIFO non-empty
- frames_done  out  16  count of ok completions, saturating at 0xFFFF

## Operation
- FIFO: push on `req_valid & req_ready`. `req_ready = !full`, with no bypass, so a push while full is never accepted even if a pop occurs in the same cycle. Pointers wrap modulo DEPTH, and an occupancy counter distinguishes full from empty.
- FSM states: IDLE, LAUNCH, RUN, FLUSH, REPORT.
- IDLE: if the FIFO is non-empty and `core_idle=1`, pop the head. Register src/dst/key/tag into `core_src_sel`/`core_dst_sel`/`core_key`/the tag register, then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: one cycle. Config lines are stable and `core_start=0`. Clear the watchdog, then go to RUN.
- RUN: `core_start=1`, watchdog increments each cycle.
  - If `core_done=1`, go to REPORT with status 00.
  - Otherwise, if the watchdog equals TIMEOUT-1, go to FLUSH.
  - If `core_done` arrives in the same cycle as the timeout, done wins and status is 00.
- FLUSH: `core_start=0` and `core_rst=1` for exactly 2 cycles, then go to REPORT with status 01.
- REPORT: `cmp_valid=1` with `cmp_tag`/`cmp_status` held stable until `cmp_ready`. On the handshake, go to IDLE and increment `frames_done` if status is 00.
- `core_key`, `core_src_sel` and `core_dst_sel` change only on a pop. They are held through LAUNCH, RUN, FLUSH and REPORT.
- `core_done` outside RUN is ignored.
- The FIFO keeps accepting descriptors in every state.

## Timing
- Reset values: `req_ready` is 0 while reset is applied and 1 on the first cycle after release. All of the following are 0: `cmp_valid`, `cmp_tag`, `cmp_status`, `core_start`, `core_key`, `core_src_sel`, `core_dst_sel`, `busy`, `frames_done`.
- `core_rst` resets to 1 and falls on the first edge with `ap_rst_n=1`.
- After reset the FIFO is empty and the FSM is in IDLE.
- Reset mid-frame: the frame is abandoned with no completion reported, queued descriptors are discarded, and the core is reset via `core_rst`.
- Latency, with the push handshake at cycle t:
  - t+1: IDLE pops.
  - t+2: LAUNCH, config outputs valid.
  - t+3: first cycle of `core_start=1`.
- Completion path: `core_done` sampled in cycle d gives `core_start=0` and `cmp_valid=1` from d+1.
- Back-to-back frames: `cmp` handshake at cycle r gives IDLE at r+1 (`frames_done` updated), LAUNCH at r+2, and `core_start` at r+3.
- Timeout: the last RUN cycle has watchdog = TIMEOUT-1. FLUSH occupies the next 2 cycles and `cmp_valid` rises the cycle after that.
- `busy` is registered and updated one cycle after the state or occupancy change.

## Test plan
- Single frame: push {src=1, dst=2, key=5, tag=3}. Core model asserts done 20 cycles after start. Expect `core_key=5` and sels 1/2 from t+2, `core_start` high from t+3 for 20 cycles, then `cmp_valid` with tag=3, status=00, and `frames_done=1`.
- FIFO full: with the core stalled, push 5 descriptors back-to-back (DEPTH=4). Expect the first popped, the next 4 queued, and `req_ready=0` while 4 entries are held. Completions return tags in push order with no loss.
- Timeout (TIMEOUT=64): core never asserts done. Expect 64 RUN cycles, `core_rst=1` for 2 cycles, then `cmp_status=01`, and `frames_done` unchanged.
- Done on the same cycle as timeout (TIMEOUT=64, done on the 64th RUN cycle): expect status 00, no `core_rst` pulse.
- Completion backpressure: hold `cmp_ready=0` for 10 cycles with a second descriptor queued. `cmp` fields stay stable and no second launch occurs until the handshake, after which `core_start` rises 3 cycles later.
- Reset mid-RUN with 2 descriptors queued: drop `ap_rst_n` for 1 cycle. Expect all outputs at reset values, `core_rst=1` then 0, FIFO empty, and no `cmp_valid`. A later push launches normally; `core_idle=0` in IDLE holds the launch off.
